reg_writeback_buffer: RTL and testbench

Write-back buffer sitting directly upstream of the 32 x 32-bit register file write port. Accepts register-write requests from the execute stage through a valid/ready handshake and holds them in a small FIFO. Retires them in order, one per cycle, onto the register file's write-select, write-address and write-data inputs. Also provides read-after-write forwarding for the two register file read selectors, so that pending, not-yet-written values are visible to consumers.

---
 rtl/reg_writeback_buffer.sv | 130 +++++++++++++
 tb/tb_reg_writeback_buffer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_buffer.sv
// Write-back buffer in front of the register file write port.
// In-order FIFO of {sel, data} write requests, retired one per cycle when the
// write port is free, with newest-value forwarding for two read selectors.
module reg_writeback_buffer #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   // execute-stage request
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ADDR_W-1:0]         in_sel,
   input  logic [DATA_W-1:0]         in_data,
   // register file write port
   input  logic                      drain_en,
   output logic                      rf_write_sel,
   output logic [ADDR_W-1:0]         rf_sel_write,
   output logic [DATA_W-1:0]         rf_data_write,
   // read-after-write forwarding
   input  logic [ADDR_W-1:0]         fwd_sel1,
   input  logic [ADDR_W-1:0]         fwd_sel2,
   output logic                      fwd_hit1,
   output logic                      fwd_hit2,
   output logic [DATA_W-1:0]         fwd_data1,
   output logic [DATA_W-1:0]         fwd_data2,
   // occupancy
   output logic [$clog2(DEPTH):0]    count,
   output logic                      empty,
   output logic                      full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] sel_mem_q  [DEPTH];
   logic [DATA_W-1:0] data_mem_q [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              push;
   logic              pop;

   // Flags and handshake come only from registered occupancy.
   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == CNT_W'(DEPTH));
      in_ready = !full;
      count    = count_q;
      push     = in_valid && in_ready;
      pop      = !empty && drain_en;
   end

   // Head entry drives the write port; zeroed when nothing is pending.
   always_comb begin
      rf_write_sel  = pop;
      rf_sel_write  = '0;
      rf_data_write = '0;
      if (!empty) begin
         rf_sel_write  = sel_mem_q[rd_ptr_q];
         rf_data_write = data_mem_q[rd_ptr_q];
      end
   end

   // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state with asynchronous reset; pending writes are discarded.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage is not reset; only occupied slots are ever observed.
   always_ff @(posedge clk) begin
      if (push) begin
         sel_mem_q[wr_ptr_q]  <= in_sel;
         data_mem_q[wr_ptr_q] <= in_data;
      end
   end

   // Forwarding scans oldest to newest so the last match is the newest value.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx       = '0;
      fwd_hit1  = 1'b0;
      fwd_hit2  = 1'b0;
      fwd_data1 = '0;
      fwd_data2 = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_q + PTR_W'(i);
         if (CNT_W'(i) < count_q) begin
            if (sel_mem_q[idx] == fwd_sel1) begin
               fwd_hit1  = 1'b1;
               fwd_data1 = data_mem_q[idx];
            end
            if (sel_mem_q[idx] == fwd_sel2) begin
               fwd_hit2  = 1'b1;
               fwd_data2 = data_mem_q[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_writeback_buffer.sv
// Scoreboard bench for reg_writeback_buffer: accepted requests are queued as
// expected retirements; a negedge monitor checks every register file write.
module tb_reg_writeback_buffer;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] sel;
      logic [DATA_W-1:0] data;
   } ent_t;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   in_valid;
   logic                   in_ready;
   logic [ADDR_W-1:0]      in_sel;
   logic [DATA_W-1:0]      in_data;
   logic                   drain_en;
   logic                   rf_write_sel;
   logic [ADDR_W-1:0]      rf_sel_write;
   logic [DATA_W-1:0]      rf_data_write;
   logic [ADDR_W-1:0]      fwd_sel1;
   logic [ADDR_W-1:0]      fwd_sel2;
   logic                   fwd_hit1;
   logic                   fwd_hit2;
   logic [DATA_W-1:0]      fwd_data1;
   logic [DATA_W-1:0]      fwd_data2;
   logic [$clog2(DEPTH):0] count;
   logic                   empty;
   logic                   full;

   ent_t                   exp_q[$];
   logic [DATA_W-1:0]      rf_model [32];
   int                     n_checks = 0;
   int                     n_errors = 0;
   bit                     loop_done;

   reg_writeback_buffer #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sel       (in_sel),
      .in_data      (in_data),
      .drain_en     (drain_en),
      .rf_write_sel (rf_write_sel),
      .rf_sel_write (rf_sel_write),
      .rf_data_write(rf_data_write),
      .fwd_sel1     (fwd_sel1),
      .fwd_sel2     (fwd_sel2),
      .fwd_hit1     (fwd_hit1),
      .fwd_hit2     (fwd_hit2),
      .fwd_data1    (fwd_data1),
      .fwd_data2    (fwd_data2),
      .count        (count),
      .empty        (empty),
      .full         (full)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Align to just after a rising edge.
   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Call aligned just after a rising edge; returns aligned after acceptance.
   task automatic push(input logic [ADDR_W-1:0] sel, input logic [DATA_W-1:0] data);
      ent_t e;
      int   tries;
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = data;
      tries    = 0;
      @(negedge clk);
      while (!in_ready && tries < 50) begin
         @(negedge clk);
         tries++;
      end
      if (!in_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL push_timeout: in_ready %0b, expected 1 within 50 cycles", in_ready);
      end else begin
         e.sel  = sel;
         e.data = data;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Monitor: every register file write must match the oldest expected entry.
   always @(negedge clk) begin
      ent_t e;
      if (!reset && rf_write_sel) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: sel %0d data %0h, expected no write",
                     rf_sel_write, rf_data_write);
         end else begin
            e = exp_q.pop_front();
            check("drain_sel", 32'(rf_sel_write), 32'(e.sel));
            check("drain_data", rf_data_write, e.data);
            rf_model[rf_sel_write] = rf_data_write;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_sel   = '0;
      in_data  = '0;
      drain_en = 1'b0;
      fwd_sel1 = '0;
      fwd_sel2 = '0;
      for (int i = 0; i < 32; i++) rf_model[i] = 32'hdead_beef;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_rf_write_sel", 32'(rf_write_sel), 0);
      check("rst_rf_sel_write", 32'(rf_sel_write), 0);
      check("rst_rf_data_write", rf_data_write, 0);
      check("rst_fwd_hit1", 32'(fwd_hit1), 0);
      check("rst_fwd_data1", fwd_data1, 0);
      sync();
      reset = 1'b0;

      // Single write with the port free: retired the following cycle
      drain_en = 1'b1;
      push(5'd3, 32'd9);
      @(negedge clk);
      check("t1_count_pending", 32'(count), 1);
      check("t1_write_sel", 32'(rf_write_sel), 1);
      @(negedge clk);
      check("t1_count_after", 32'(count), 0);
      check("t1_rf3", rf_model[3], 32'd9);
      drain_en = 1'b0;
      sync();

      // Fill with the port blocked
      for (int k = 1; k <= 4; k++) push(5'(k), 32'(k * 10));
      fwd_sel1 = 5'd2;
      @(negedge clk);
      check("t2_full", 32'(full), 1);
      check("t2_in_ready", 32'(in_ready), 0);
      check("t2_count", 32'(count), 4);
      check("t2_fwd_hit1", 32'(fwd_hit1), 1);
      check("t2_fwd_data1", fwd_data1, 32'd20);
      sync();
      in_valid = 1'b1;
      in_sel   = 5'd5;
      in_data  = 32'd50;
      @(negedge clk);
      check("t2_fifth_ready", 32'(in_ready), 0);
      sync();
      in_valid = 1'b0;
      @(negedge clk);
      check("t2_fifth_count", 32'(count), 4);
      sync();
      drain_en = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("t2_drained_count", 32'(count), 0);
      check("t2_drained_empty", 32'(empty), 1);
      drain_en = 1'b0;
      sync();

      // Forwarding picks the newest matching entry
      push(5'd7, 32'd5);
      push(5'd7, 32'd6);
      fwd_sel1 = 5'd7;
      fwd_sel2 = 5'd8;
      @(negedge clk);
      check("t3_fwd_hit1", 32'(fwd_hit1), 1);
      check("t3_fwd_data1", fwd_data1, 32'd6);
      check("t3_fwd_hit2", 32'(fwd_hit2), 0);
      check("t3_fwd_data2", fwd_data2, 32'd0);
      sync();
      drain_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("t3_count", 32'(count), 0);
      check("t3_rf7", rf_model[7], 32'd6);
      drain_en = 1'b0;
      sync();

      // Simultaneous push and pop at count 2
      push(5'd10, 32'd100);
      push(5'd11, 32'd110);
      drain_en = 1'b1;
      push(5'd12, 32'd120);
      @(negedge clk);
      check("t4_count_steady", 32'(count), 2);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("t4_count_empty", 32'(count), 0);
      drain_en = 1'b0;
      sync();

      // 32 writes with the port toggling every cycle, wrapping several times
      loop_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 32; i++) push(5'(i), 32'(i * i));
            loop_done = 1'b1;
         end
         begin
            while (!loop_done) begin
               @(posedge clk);
               #1;
               drain_en = ~drain_en;
            end
         end
      join
      drain_en = 1'b1;
      repeat (DEPTH + 2) @(posedge clk);
      @(negedge clk);
      check("t4_loop_count", 32'(count), 0);
      for (int i = 0; i < 32; i++) check("t4_rf_square", rf_model[i], 32'(i * i));
      drain_en = 1'b0;
      sync();

      // Asynchronous reset while draining
      push(5'd20, 32'd1);
      push(5'd21, 32'd2);
      push(5'd22, 32'd3);
      fwd_sel1 = 5'd21;
      drain_en = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("t5_count", 32'(count), 0);
      check("t5_empty", 32'(empty), 1);
      check("t5_full", 32'(full), 0);
      check("t5_in_ready", 32'(in_ready), 1);
      check("t5_write_sel", 32'(rf_write_sel), 0);
      check("t5_sel_write", 32'(rf_sel_write), 0);
      check("t5_data_write", rf_data_write, 0);
      check("t5_fwd_hit1", 32'(fwd_hit1), 0);
      check("t5_fwd_data1", fwd_data1, 0);
      exp_q.delete();
      sync();
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t5_no_write", 32'(rf_write_sel), 0);
      end
      check("t5_count_after", 32'(count), 0);
      drain_en = 1'b0;
      sync();

      // Drain stall: head held, forwarding stays visible
      push(5'd5, 32'd55);
      fwd_sel1 = 5'd5;
      repeat (5) begin
         @(negedge clk);
         check("t6_write_sel", 32'(rf_write_sel), 0);
         check("t6_sel_write", 32'(rf_sel_write), 5);
         check("t6_data_write", rf_data_write, 32'd55);
         check("t6_fwd_hit1", 32'(fwd_hit1), 1);
      end
      sync();
      drain_en = 1'b1;
      @(negedge clk);
      sync();
      @(negedge clk);
      check("t6_count", 32'(count), 0);
      check("t6_rf5", rf_model[5], 32'd55);

      check("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
